// File: rtl/result_collector.sv
// Merges NUM_SOLVERS solver result streams onto one output stream.
// Streams are forwarded whole, solvers are picked round-robin, and each beat is tagged with its source.

module result_collector_lane #(
  parameter int ID_WIDTH = 1,
  parameter int IDX      = 0
) (
  input  logic                locked,
  input  logic [ID_WIDTH-1:0] grant,
  input  logic                accept,
  output logic                ready
);
  assign ready = locked && (grant == ID_WIDTH'(IDX)) && accept;
endmodule

module result_collector #(
  parameter int NUM_SOLVERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = $clog2(NUM_SOLVERS)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_SOLVERS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SOLVERS-1:0]            in_valid,
  input  logic [NUM_SOLVERS-1:0]            in_end_of_stream,
  output logic [NUM_SOLVERS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [ID_WIDTH-1:0]               out_source,
  output logic                              out_valid,
  output logic                              out_end_of_stream,
  input  logic                              out_ready
);

  typedef enum logic {SCAN, LOCKED} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   source;
    logic                  eos;
  } beat_t;

  state_t                                 state, state_nxt;
  logic [ID_WIDTH-1:0]                    grant, grant_nxt;
  logic [ID_WIDTH-1:0]                    last_grant, last_nxt;
  logic [ID_WIDTH-1:0]                    cand;
  logic                                   found;
  logic [NUM_SOLVERS-1:0][DATA_WIDTH-1:0] in_lanes;
  logic                                   locked, accept, in_xfer;
  beat_t                                  out_q;

  assign in_lanes = in_data;
  assign locked   = (state == LOCKED);
  assign accept   = !out_valid || out_ready;
  assign in_xfer  = |(in_valid & in_ready);

  for (genvar i = 0; i < NUM_SOLVERS; i++) begin : g_lane
    result_collector_lane #(.ID_WIDTH(ID_WIDTH), .IDX(i)) u_lane (
      .locked (locked),
      .grant  (grant),
      .accept (accept),
      .ready  (in_ready[i])
    );
  end

  // Arbitration: scan starts one past the last finished solver, so it is served last.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_grant;
    cand      = '0;
    found     = 1'b0;
    case (state)
      SCAN: begin
        for (int k = 1; k <= NUM_SOLVERS; k++) begin
          cand = ID_WIDTH'((int'(last_grant) + k) % NUM_SOLVERS);
          if (!found && in_valid[cand]) begin
            found     = 1'b1;
            grant_nxt = cand;
          end
        end
        if (found) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (in_xfer && in_end_of_stream[grant]) begin
          last_nxt  = grant;
          state_nxt = SCAN;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      grant      <= '0;
      last_grant <= ID_WIDTH'(NUM_SOLVERS - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
    end
  end

  // Output register reloads on the same edge it drains, giving 1 beat/cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (in_xfer) begin
      out_q.data   <= in_lanes[grant];
      out_q.source <= grant;
      out_q.eos    <= in_end_of_stream[grant];
      out_valid    <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data          = out_q.data;
  assign out_source        = out_q.source;
  assign out_end_of_stream = out_q.eos;

endmodule

// File: tb/tb_result_collector.sv
// Randomized and directed bench for result_collector with a round-robin stream-level reference model.

module tb_result_collector;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int IW = $clog2(NS);
  localparam int QD = 256;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [NS*DW-1:0] in_data = '0;
  logic [NS-1:0]  in_valid = '0, in_eos = '0, in_ready;
  logic [DW-1:0]  out_data;
  logic [IW-1:0]  out_source;
  logic           out_valid, out_eos;
  logic           out_ready = 1'b0;

  result_collector #(.NUM_SOLVERS(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clock             (clock),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_end_of_stream  (in_eos),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_source        (out_source),
    .out_valid         (out_valid),
    .out_end_of_stream (out_eos),
    .out_ready         (out_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] d;
    int            src;
    logic          eos;
  } exp_t;

  int           n_tests = 0, n_fail = 0;
  logic [DW:0]  sbuf [NS][QD];
  int           shead [NS], stail [NS];
  bit           gap [NS];
  exp_t         expq [$];
  int           out_cyc [$];
  int           cyc = 0, start = 0, mode = 0, model_last = NS - 1;
  bit           gaps_en = 0, held = 0, seen51 = 0;
  logic [DW-1:0] pd;
  logic [IW-1:0] ps;
  logic          pe;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < NS; i++) begin
      shead[i] = 0; stail[i] = 0; gap[i] = 0;
    end
    expq.delete();
  endtask

  task automatic push(input int s, input logic [DW-1:0] d, input logic e);
    sbuf[s][stail[s]] = {e, d};
    stail[s]++;
  endtask

  // Whole streams leave in round-robin order among solvers that still have one queued.
  task automatic build_expected();
    int h [NS];
    int found;
    exp_t e;
    for (int i = 0; i < NS; i++) h[i] = shead[i];
    forever begin
      found = -1;
      for (int k = 1; k <= NS; k++) begin
        int s;
        s = (model_last + k) % NS;
        if (found < 0 && h[s] < stail[s]) found = s;
      end
      if (found < 0) break;
      do begin
        e.d   = sbuf[found][h[found]][DW-1:0];
        e.eos = sbuf[found][h[found]][DW];
        e.src = found;
        expq.push_back(e);
        h[found]++;
      end while (!e.eos);
      model_last = found;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (shead[i] < stail[i] && !gap[i]) begin
        in_valid[i]          = 1'b1;
        in_data[i*DW +: DW]  = sbuf[i][shead[i]][DW-1:0];
        in_eos[i]            = sbuf[i][shead[i]][DW];
      end else begin
        in_valid[i] = 1'b0;
        in_eos[i]   = 1'b0;
      end
    end
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1));
      default: out_ready = ((cyc - start) % 3 == 0);
    endcase
  endtask

  task automatic begin_scenario(input int m, input bit g);
    mode = m; gaps_en = g; start = cyc;
    out_cyc.delete();
    build_expected();
    drive();
  endtask

  task automatic step();
    logic [NS-1:0] acc;
    @(negedge clock);
    acc = in_valid & in_ready;
    check("rdy_onehot", 64'($countones(in_ready) <= 1), 1);
    if (out_valid && !out_ready) check("stall_rdy", in_ready, 0);
    if (held) begin
      check("hold_data", out_data, pd);
      check("hold_src", out_source, ps);
      check("hold_eos", out_eos, pe);
    end
    if (out_valid && out_ready) begin
      check("beat_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        check("out_data", out_data, e.d);
        check("out_src", out_source, e.src);
        check("out_eos", out_eos, e.eos);
      end
      out_cyc.push_back(cyc);
      if (out_data == 51) seen51 = 1;
    end
    held = out_valid && !out_ready;
    pd = out_data; ps = out_source; pe = out_eos;
    @(posedge clock); #1;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) begin
        logic e;
        e = sbuf[i][shead[i]][DW];
        shead[i]++;
        gap[i] = gaps_en && !e && ($urandom_range(2) == 0);
      end else if (gap[i] && $urandom_range(1) == 1) begin
        gap[i] = 0;
      end
    end
    drive();
  endtask

  task automatic run(input int bound);
    int n = 0;
    while (expq.size() > 0 && n < bound) begin
      step();
      n++;
    end
    check("drain", expq.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_q();
    #2 reset = 1'b0;
    @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_data", out_data, 0);
    check("rst_src", out_source, 0);
    check("rst_eos", out_eos, 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Two streams contending from the first cycle: 0 wins, one idle cycle between.
    clear_q();
    push(0, 10, 0); push(0, 11, 1);
    push(1, 20, 0); push(1, 21, 0); push(1, 22, 1);
    begin_scenario(0, 0);
    run(50);
    check("s2_latency", out_cyc[0] - start, 2);
    check("s2_gap", out_cyc[2] - out_cyc[1], 2);

    // Both valid again: solver 0 goes first after solver 1 finished.
    clear_q();
    push(1, 23, 1); push(0, 12, 1);
    begin_scenario(0, 0);
    run(50);

    clear_q();
    push(1, 24, 0); push(1, 25, 1);
    begin_scenario(0, 0);
    run(50);

    // Lone solver 0 stream: consecutive beats, first one 2 cycles in.
    clear_q();
    push(0, 5, 0); push(0, 6, 0); push(0, 7, 1);
    begin_scenario(0, 0);
    run(50);
    check("s1_latency", out_cyc[0] - start, 2);
    check("s1_stream", out_cyc[2] - out_cyc[0], 2);

    // Backpressure with out_ready 1,0,0 repeating.
    clear_q();
    for (int v = 1; v <= 4; v++) push(1, DW'(v), v == 4);
    begin_scenario(2, 0);
    run(100);

    // Single-beat streams alternate.
    clear_q();
    for (int r = 0; r < 3; r++) begin
      push(0, 30, 1); push(1, 40, 1);
    end
    begin_scenario(0, 0);
    run(100);

    // Random streams on all solvers with mid-stream gaps and random out_ready.
    clear_q();
    for (int s = 0; s < NS; s++)
      for (int t = 0; t < 5; t++) begin
        int len;
        len = $urandom_range(4, 1);
        for (int b = 0; b < len; b++) push(s, DW'($urandom), b == len - 1);
      end
    begin_scenario(1, 1);
    run(3000);

    // Reset in the middle of a stream.
    clear_q();
    seen51 = 0;
    push(0, 50, 0); push(0, 51, 0); push(0, 52, 1);
    begin_scenario(0, 0);
    for (int n = 0; n < 20 && !seen51; n++) step();
    check("saw_51", seen51, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_eos", out_eos, 0);
    clear_q();
    held = 0;
    model_last = NS - 1;
    drive();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    push(2, 70, 1);
    push(0, 60, 0); push(0, 61, 1);
    begin_scenario(0, 0);
    run(50);
    check("post_rst_latency", out_cyc[0] - start, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
